// File: rtl/frame_buf_ctrl.sv
// Frame-aware circular buffer controller around a dual-port RAM.
// Commits clean frames, rolls back errored ones, streams frames out whole.
module frame_buf_ctrl #(
  parameter int WIDTH      = 8,
  parameter int WORDS      = 1024,
  parameter int ADDR_WIDTH = $clog2(WORDS),
  parameter int LEN_DEPTH  = 16,
  parameter int RD_LAT     = 2
) (
  input  logic                         iclk,
  input  logic                         irst,
  input  logic [WIDTH-1:0]             idata,
  input  logic                         ival,
  input  logic                         isop,
  input  logic                         ieop,
  input  logic                         ierr,
  output logic [WIDTH-1:0]             owr_data,
  output logic [ADDR_WIDTH-1:0]        owr_addr,
  output logic                         owr_ena,
  output logic [ADDR_WIDTH-1:0]        ord_addr,
  output logic                         ord_ena,
  input  logic [WIDTH-1:0]             iram_data,
  input  logic                         iram_val,
  input  logic                         istart,
  output logic                         oframe_avail,
  output logic [$clog2(LEN_DEPTH):0]   oframe_cnt,
  output logic [ADDR_WIDTH:0]          ofree,
  output logic [WIDTH-1:0]             odata,
  output logic                         oval,
  output logic                         osop,
  output logic                         oeop,
  output logic                         odrop
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int LA = $clog2(LEN_DEPTH);
  localparam int CW = LA + 1;

  typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_READ} rstate_t;

  wstate_t ws, ws_n;
  rstate_t rs, rs_n;

  logic [PW-1:0] wr_ptr, wr_ptr_n;
  logic [PW-1:0] frm_start, frm_start_n;
  logic [PW-1:0] len, len_n;
  logic [PW-1:0] rd_ptr, rem;
  logic [PW-1:0] free, base, base_free, wr_at;
  logic          push, pop, drop, wr_en;
  logic          start, cont, absorb;
  logic          rd_en, sop_t, eop_t, first;

  logic [PW-1:0] len_mem [LEN_DEPTH];
  logic [CW-1:0] lf_wp, lf_rp, lf_cnt;
  logic          lf_full;

  logic [2:0]    tag_pipe [RD_LAT];
  logic [2:0]    tag;

  assign lf_cnt  = lf_wp - lf_rp;
  assign lf_full = lf_cnt == CW'(LEN_DEPTH);
  assign free    = PW'(WORDS) - (wr_ptr - rd_ptr);

  // A restart mid-frame reuses the aborted frame's start address
  assign base      = (ws == W_FRAME) ? frm_start : wr_ptr;
  assign base_free = PW'(WORDS) - (base - rd_ptr);

  assign start  = ival & isop & (ws != W_DROP);
  assign cont   = ival & ~isop & (ws == W_FRAME);
  assign absorb = ival & (ws == W_DROP);

  always_comb begin
    ws_n        = ws;
    wr_ptr_n    = wr_ptr;
    frm_start_n = frm_start;
    len_n       = len;
    push        = 1'b0;
    drop        = 1'b0;
    wr_en       = 1'b0;
    wr_at       = wr_ptr;
    unique case (1'b1)
      start: begin
        drop        = (ws == W_FRAME);
        frm_start_n = base;
        len_n       = PW'(1);
        wr_ptr_n    = base;
        if (lf_full || base_free == '0) begin
          ws_n = W_DROP;
          if (ieop) begin
            drop = 1'b1;
            ws_n = W_IDLE;
          end
        end else begin
          wr_en    = 1'b1;
          wr_at    = base;
          wr_ptr_n = base + 1'b1;
          ws_n     = W_FRAME;
          if (ieop) begin
            ws_n = W_IDLE;
            if (ierr) begin
              drop     = 1'b1;
              wr_ptr_n = base;
            end else begin
              push = 1'b1;
            end
          end
        end
      end
      cont: begin
        if (free == '0) begin
          ws_n = W_DROP;
          if (ieop) begin
            drop     = 1'b1;
            wr_ptr_n = frm_start;
            ws_n     = W_IDLE;
          end
        end else begin
          wr_en    = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          len_n    = len + 1'b1;
          if (ieop) begin
            ws_n = W_IDLE;
            if (ierr) begin
              drop     = 1'b1;
              wr_ptr_n = frm_start;
            end else begin
              push = 1'b1;
            end
          end
        end
      end
      absorb: begin
        if (ieop) begin
          drop     = 1'b1;
          wr_ptr_n = frm_start;
          ws_n     = W_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rs_n  = rs;
    pop   = 1'b0;
    rd_en = 1'b0;
    sop_t = 1'b0;
    eop_t = 1'b0;
    unique case (rs)
      R_IDLE: begin
        if (istart && lf_cnt != '0) begin
          pop  = 1'b1;
          rs_n = R_READ;
        end
      end
      R_READ: begin
        rd_en = 1'b1;
        sop_t = first;
        eop_t = (rem == PW'(1));
        if (rem == PW'(1)) rs_n = R_IDLE;
      end
      default: rs_n = R_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      ws        <= W_IDLE;
      rs        <= R_IDLE;
      wr_ptr    <= '0;
      frm_start <= '0;
      len       <= '0;
      rd_ptr    <= '0;
      rem       <= '0;
      first     <= 1'b0;
      lf_wp     <= '0;
      lf_rp     <= '0;
      odrop     <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      ws        <= ws_n;
      rs        <= rs_n;
      wr_ptr    <= wr_ptr_n;
      frm_start <= frm_start_n;
      len       <= len_n;
      odrop     <= drop;
      if (push) lf_wp <= lf_wp + 1'b1;
      if (pop) begin
        lf_rp <= lf_rp + 1'b1;
        rem   <= len_mem[lf_rp[LA-1:0]];
        first <= 1'b1;
      end else if (rd_en) begin
        rem   <= rem - 1'b1;
        first <= 1'b0;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      tag_pipe[0] <= {rd_en, sop_t, eop_t};
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge iclk) begin
    if (push) len_mem[lf_wp[LA-1:0]] <= len_n;
  end

  assign owr_data     = idata;
  assign owr_addr     = wr_at[ADDR_WIDTH-1:0];
  assign owr_ena      = wr_en;
  assign ord_addr     = rd_ptr[ADDR_WIDTH-1:0];
  assign ord_ena      = rd_en;
  assign oframe_avail = lf_cnt != '0;
  assign oframe_cnt   = lf_cnt;
  assign ofree        = free;

  // The tag valid bit masks stale RAM valids after reset
  assign tag   = tag_pipe[RD_LAT-1];
  assign odata = iram_data;
  assign oval  = iram_val & tag[2];
  assign osop  = oval & tag[1];
  assign oeop  = oval & tag[0];

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl with a 2-cycle dual-port RAM model.
module tb_frame_buf_ctrl;

  logic        clk = 1'b0;
  logic        irst;
  logic [7:0]  idata;
  logic        ival, isop, ieop, ierr, istart;
  logic [7:0]  owr_data, odata, ram_data;
  logic [9:0]  owr_addr, ord_addr;
  logic        owr_ena, ord_ena, oframe_avail;
  logic        oval, osop, oeop, odrop;
  logic        ram_val = 1'b0;
  logic [2:0]  oframe_cnt;
  logic [10:0] ofree;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_buf_ctrl #(.WIDTH(8), .WORDS(1024), .LEN_DEPTH(4), .RD_LAT(2)) dut (
    .iclk(clk), .irst(irst), .idata(idata), .ival(ival),
    .isop(isop), .ieop(ieop), .ierr(ierr),
    .owr_data(owr_data), .owr_addr(owr_addr), .owr_ena(owr_ena),
    .ord_addr(ord_addr), .ord_ena(ord_ena),
    .iram_data(ram_data), .iram_val(ram_val),
    .istart(istart), .oframe_avail(oframe_avail),
    .oframe_cnt(oframe_cnt), .ofree(ofree),
    .odata(odata), .oval(oval), .osop(osop), .oeop(oeop),
    .odrop(odrop)
  );

  logic [7:0] mem [1024];
  logic       r1_en = 1'b0;
  logic [9:0] r1_addr = '0;

  always @(posedge clk) begin
    if (owr_ena) mem[owr_addr] <= owr_data;
    r1_en    <= ord_ena;
    r1_addr  <= ord_addr;
    ram_val  <= r1_en;
    ram_data <= mem[r1_addr];
  end

  logic [7:0] rxq [$];
  int cyc = 0, sop_cnt = 0, eop_cnt = 0, gaps = 0, drop_cnt = 0;
  int first_rd = -1, first_val = -1;
  logic in_fr = 1'b0;
  logic [7:0] sop_byte, eop_byte;
  logic clr_req = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr_req) begin
      rxq.delete();
      sop_cnt <= 0; eop_cnt <= 0; gaps <= 0; drop_cnt <= 0;
      first_rd <= -1; first_val <= -1; in_fr <= 1'b0;
    end else begin
      if (ord_ena && first_rd < 0) first_rd <= cyc;
      if (oval === 1'b1) begin
        if (first_val < 0) first_val <= cyc;
        rxq.push_back(odata);
        if (osop) begin
          sop_cnt <= sop_cnt + 1; sop_byte <= odata; in_fr <= 1'b1;
        end
        if (oeop) begin
          eop_cnt <= eop_cnt + 1; eop_byte <= odata; in_fr <= 1'b0;
        end
      end else if (in_fr) begin
        gaps <= gaps + 1;
      end
      if (odrop === 1'b1) drop_cnt <= drop_cnt + 1;
    end
  end

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    @(posedge clk); #1 clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 irst = 1'b1;
    repeat (2) @(posedge clk);
    #1 irst = 1'b0;
  endtask

  task automatic send(input int n, input int base, input bit err,
                      output int faddr, output int wraps,
                      output int av_eop);
    int prev;
    prev = -1;
    wraps = 0;
    faddr = -1;
    av_eop = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ival  = 1'b1;
      idata = 8'(base + i);
      isop  = (i == 0);
      ieop  = (i == n - 1);
      ierr  = err && (i == n - 1);
      @(negedge clk);
      if (i == 0) faddr = int'(owr_addr);
      if (owr_ena && prev == 1023 && owr_addr == 10'd0) wraps++;
      if (owr_ena) prev = int'(owr_addr);
      if (i == n - 1) av_eop = int'(oframe_avail);
    end
    @(posedge clk); #1;
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; ierr = 1'b0;
  endtask

  task automatic wait_rx(string tag, int n, int lim);
    int c;
    c = 0;
    while (rxq.size() < n && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk(tag, int'(rxq.size() >= n), 1);
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_data(string tag, int n, int base);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (i >= rxq.size() || rxq[i] !== 8'(base + i)) bad++;
    chk(tag, bad, 0);
    chk({tag, "_len"}, rxq.size(), n);
  endtask

  int fa, fb, wr, av, nv;

  initial begin
    irst = 1'b1; ival = 0; isop = 0; ieop = 0; ierr = 0;
    idata = '0; istart = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_free", int'(ofree), 1024);
    chk("rst_cnt", int'(oframe_cnt), 0);
    chk("rst_avail", int'(oframe_avail), 0);
    chk("rst_oval", int'(oval), 0);
    chk("rst_wr_ena", int'(owr_ena), 0);
    chk("rst_rd_ena", int'(ord_ena), 0);
    chk("rst_drop", int'(odrop), 0);
    @(posedge clk); #1 irst = 1'b0;

    // 1: 64-byte frame read back as soon as committed
    clr();
    istart = 1'b1;
    send(64, 0, 0, fa, wr, av);
    chk("t1_avail_eop", av, 0);
    @(negedge clk);
    chk("t1_avail_eop1", int'(oframe_avail), 1);
    wait_rx("t1_timeout", 64, 300);
    chk_data("t1_data", 64, 0);
    chk("t1_sop", sop_cnt, 1);
    chk("t1_eop", eop_cnt, 1);
    chk("t1_sop_byte", int'(sop_byte), 0);
    chk("t1_eop_byte", int'(eop_byte), 63);
    chk("t1_gaps", gaps, 0);
    chk("t1_latency", first_val - first_rd, 2);
    chk("t1_free", int'(ofree), 1024);

    // 2: errored frame rolls back, next frame reuses its address
    clr();
    send(100, 16, 1, fa, wr, av);
    repeat (10) @(negedge clk);
    chk("t2_drop", drop_cnt, 1);
    chk("t2_no_oval", rxq.size(), 0);
    chk("t2_free", int'(ofree), 1024);
    chk("t2_cnt", int'(oframe_cnt), 0);
    chk("t2_bad_addr", fa, 64);
    send(5, 200, 0, fb, wr, av);
    chk("t2_good_addr", fb, 64);
    wait_rx("t2_timeout", 5, 100);
    chk_data("t2_data", 5, 200);

    // 3: overflow frame dropped, exactly-full frame committed
    istart = 1'b0;
    clr();
    send(1025, 0, 0, fa, wr, av);
    repeat (5) @(negedge clk);
    chk("t3_drop", drop_cnt, 1);
    chk("t3_free_after_drop", int'(ofree), 1024);
    chk("t3_cnt_after_drop", int'(oframe_cnt), 0);
    send(1024, 7, 0, fa, wr, av);
    @(negedge clk);
    chk("t3_full_cnt", int'(oframe_cnt), 1);
    chk("t3_full_free", int'(ofree), 0);
    istart = 1'b1;
    wait_rx("t3_timeout", 1024, 1200);
    chk_data("t3_data", 1024, 7);
    chk("t3_sop", sop_cnt, 1);
    chk("t3_eop", eop_cnt, 1);
    chk("t3_gaps", gaps, 0);
    chk("t3_free", int'(ofree), 1024);

    // 4: fifth frame dropped when the length FIFO is full
    istart = 1'b0;
    clr();
    for (int k = 0; k < 5; k++) send(60, k * 60, 0, fa, wr, av);
    repeat (3) @(negedge clk);
    chk("t4_cnt", int'(oframe_cnt), 4);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_free", int'(ofree), 784);
    chk("t4_no_oval", rxq.size(), 0);
    istart = 1'b1;
    wait_rx("t4_timeout", 240, 600);
    repeat (40) @(negedge clk);
    chk_data("t4_data", 240, 0);
    chk("t4_sop", sop_cnt, 4);
    chk("t4_eop", eop_cnt, 4);
    chk("t4_cnt_end", int'(oframe_cnt), 0);

    // 5: frame that wraps the RAM address
    do_reset();
    @(negedge clk);
    chk("t5_rst_free", int'(ofree), 1024);
    clr();
    send(1000, 0, 0, fa, wr, av);
    wait_rx("t5_fill_timeout", 1000, 1200);
    clr();
    send(50, 32, 0, fa, wr, av);
    chk("t5_first_addr", fa, 1000);
    chk("t5_wraps", wr, 1);
    wait_rx("t5_timeout", 50, 200);
    chk_data("t5_data", 50, 32);
    chk("t5_sop", sop_cnt, 1);
    chk("t5_eop", eop_cnt, 1);
    chk("t5_gaps", gaps, 0);

    // 6: reset mid-read truncates output
    clr();
    send(200, 0, 0, fa, wr, av);
    begin
      int c;
      c = 0;
      while (rxq.size() < 20 && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("t6_started", int'(rxq.size() >= 20), 1);
    end
    @(posedge clk); #1 irst = 1'b1;
    @(posedge clk); #1 irst = 1'b0;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (oval !== 1'b0) nv++;
    end
    chk("t6_oval_after_rst", nv, 0);
    chk("t6_cnt", int'(oframe_cnt), 0);
    chk("t6_free", int'(ofree), 1024);
    clr();
    send(10, 90, 0, fa, wr, av);
    chk("t6_addr", fa, 0);
    wait_rx("t6_timeout", 10, 100);
    chk_data("t6_data", 10, 90);
    chk("t6_sop", sop_cnt, 1);
    chk("t6_eop", eop_cnt, 1);
    chk("t6_sop_byte", int'(sop_byte), 90);
    chk("t6_eop_byte", int'(eop_byte), 99);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
